// File: rtl/data_mem_unit_pkg.sv
// Shared definitions for the data-memory unit: RV32I width codes, opcodes and FSM states.
package data_mem_unit_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } state_e;

endpackage

// File: rtl/data_mem_unit_dmem_array.sv
// Word-organised storage with per-byte write enables and a combinational read port.
// Contents are deliberately not reset.
module dmem_array #(
  parameter int DEPTH_WORDS = 256,
  localparam int AW = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic [AW-1:0] i_idx,
  input  logic [3:0]    i_be,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [DEPTH_WORDS];

  // Byte-lane masked write.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (i_be[b]) begin
        r_mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
  end

  assign o_rdata = r_mem[i_idx];

endmodule

// File: rtl/data_mem_unit.sv
// Single-outstanding load/store unit: valid/ready request, fixed-latency commit,
// held response. Loads return the addressed word shifted down by the byte offset.
module data_mem_unit
  import data_mem_unit_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] addr,
  input  logic [2:0]  funct3,
  input  logic [31:0] wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] read_data,
  output logic        misaligned
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  state_e        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_we;
  logic [AW+1:0] r_addr;
  logic [2:0]    r_f3;
  logic [31:0]   r_wdata;
  logic [31:0]   r_rdata;
  logic          r_mis;

  logic          w_fault;
  logic [3:0]    w_lanes;
  logic [31:0]   w_wrep;
  logic          w_commit;
  logic          w_we;
  logic [3:0]    w_be;
  logic [31:0]   w_rword;
  logic [31:0]   w_load;
  logic          w_unused_addr;

  // Address bits above the array wrap and are intentionally dropped.
  assign w_unused_addr = ^addr[31:AW+2];

  // Alignment legality of the latched request.
  always_comb begin
    w_fault = 1'b1;
    case (r_f3)
      F3_B, F3_BU: w_fault = 1'b0;
      F3_H, F3_HU: w_fault = r_addr[0];
      F3_W:        w_fault = |r_addr[1:0];
      default:     w_fault = 1'b1;
    endcase
  end

  // Byte-lane selection and store data replication across lanes.
  always_comb begin
    w_lanes = 4'b0000;
    w_wrep  = r_wdata;
    case (r_f3)
      F3_B, F3_BU: begin
        w_lanes = 4'b0001 << r_addr[1:0];
        w_wrep  = {4{r_wdata[7:0]}};
      end
      F3_H, F3_HU: begin
        w_lanes = r_addr[1] ? 4'b1100 : 4'b0011;
        w_wrep  = {2{r_wdata[15:0]}};
      end
      F3_W: begin
        w_lanes = 4'b1111;
        w_wrep  = r_wdata;
      end
      default: begin
        w_lanes = 4'b0000;
        w_wrep  = r_wdata;
      end
    endcase
  end

  // Gating on reset keeps a write from landing on an edge that coincides with reset.
  assign w_commit = (r_state == WAIT) && (r_cnt == '0) && !reset;
  assign w_we     = w_commit && r_we && !w_fault;
  assign w_be     = w_we ? w_lanes : 4'b0000;
  assign w_load   = w_rword >> {r_addr[1:0], 3'b000};

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_array (
    .clk    (clk),
    .i_idx  (r_addr[AW+1:2]),
    .i_be   (w_be),
    .i_wdata(w_wrep),
    .o_rdata(w_rword)
  );

  // Request/response sequencing, latency counter and response capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_f3    <= 3'b000;
      r_wdata <= 32'h0000_0000;
      r_rdata <= 32'h0000_0000;
      r_mis   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_we    <= req_we;
            r_addr  <= addr[AW+1:0];
            r_f3    <= funct3;
            r_wdata <= wdata;
            r_cnt   <= CW'(LATENCY - 1);
            r_state <= WAIT;
          end else begin
            r_state <= IDLE;
          end
        end
        WAIT: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CW'(1);
          end else begin
            r_rdata <= (w_fault || r_we) ? 32'h0000_0000 : w_load;
            r_mis   <= w_fault;
            r_state <= RESP;
          end
        end
        RESP: begin
          if (resp_ready) begin
            r_state <= IDLE;
          end else begin
            r_state <= RESP;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready  = (r_state == IDLE) && !reset;
  assign resp_valid = (r_state == RESP);
  assign read_data  = r_rdata;
  assign misaligned = r_mis;

endmodule

// File: tb/tb_data_mem_unit.sv
// Directed bench for data_mem_unit: vector table of load/store transactions plus
// hand-written backpressure and reset-during-operation sequences.
module tb_data_mem_unit;

  localparam int LAT = 2;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] addr;
  logic [2:0]  funct3;
  logic [31:0] wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] read_data;
  logic        misaligned;

  int total;
  int bad;

  typedef struct {
    logic        we;
    logic [31:0] a;
    logic [2:0]  f3;
    logic [31:0] wd;
    logic [31:0] erd;
    logic        emis;
  } vec_t;

  vec_t vecs[16];

  data_mem_unit #(
    .DEPTH_WORDS(256),
    .LATENCY    (LAT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .addr      (addr),
    .funct3    (funct3),
    .wdata     (wdata),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .read_data (read_data),
    .misaligned(misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h required=0x%08h", name, got, exp);
    end
  endtask

  // One full transaction; returns response data, fault flag and accept-to-response latency.
  task automatic xact(input logic we, input logic [31:0] a, input logic [2:0] f3,
                      input logic [31:0] wd, output logic [31:0] rd, output logic mis,
                      output int lat);
    int n;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = we;
    addr      = a;
    funct3    = f3;
    wdata     = wd;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("accept_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat = 0;
    while (!resp_valid && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (lat >= 50) chk("resp_timeout", 32'd1, 32'd0);
    rd  = read_data;
    mis = misaligned;
    @(negedge clk);
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    logic        mis;
    int          lat;
    int          n;

    total = 0;
    bad   = 0;

    vecs[0]  = '{1'b1, 32'h10,  3'b010, 32'h5C3D5467, 32'h0,        1'b0};
    vecs[1]  = '{1'b0, 32'h10,  3'b010, 32'h0,        32'h5C3D5467, 1'b0};
    vecs[2]  = '{1'b1, 32'h13,  3'b000, 32'h000000AA, 32'h0,        1'b0};
    vecs[3]  = '{1'b0, 32'h10,  3'b010, 32'h0,        32'hAA3D5467, 1'b0};
    vecs[4]  = '{1'b0, 32'h13,  3'b100, 32'h0,        32'h000000AA, 1'b0};
    vecs[5]  = '{1'b1, 32'h12,  3'b001, 32'h0000BEEF, 32'h0,        1'b0};
    vecs[6]  = '{1'b0, 32'h12,  3'b101, 32'h0,        32'h0000BEEF, 1'b0};
    vecs[7]  = '{1'b0, 32'h10,  3'b010, 32'h0,        32'hBEEF5467, 1'b0};
    vecs[8]  = '{1'b0, 32'h11,  3'b010, 32'h0,        32'h0,        1'b1};
    vecs[9]  = '{1'b1, 32'h13,  3'b001, 32'h00001234, 32'h0,        1'b1};
    vecs[10] = '{1'b0, 32'h10,  3'b010, 32'h0,        32'hBEEF5467, 1'b0};
    vecs[11] = '{1'b0, 32'h11,  3'b000, 32'h0,        32'h00BEEF54, 1'b0};
    vecs[12] = '{1'b0, 32'h10,  3'b011, 32'h0,        32'h0,        1'b1};
    vecs[13] = '{1'b1, 32'h410, 3'b010, 32'h11223344, 32'h0,        1'b0};
    vecs[14] = '{1'b1, 32'h10,  3'b000, 32'hFFFFFF55, 32'h0,        1'b0};
    vecs[15] = '{1'b0, 32'h12,  3'b001, 32'h0,        32'h00001122, 1'b0};

    reset      = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    addr       = 32'h0;
    funct3     = 3'b000;
    wdata      = 32'h0;
    resp_ready = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_req_ready",  {31'd0, req_ready},  32'd0);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_read_data",  read_data,           32'h0);
    chk("rst_misaligned", {31'd0, misaligned}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_req_ready", {31'd0, req_ready}, 32'd1);

    for (int i = 0; i < 16; i++) begin
      xact(vecs[i].we, vecs[i].a, vecs[i].f3, vecs[i].wd, rd, mis, lat);
      chk($sformatf("vec%0d_read_data", i), rd, vecs[i].erd);
      chk($sformatf("vec%0d_misaligned", i), {31'd0, mis}, {31'd0, vecs[i].emis});
      chk($sformatf("vec%0d_latency", i), lat, LAT);
    end
    // Word at 0x10 now reads 0x11223355 (wrapped SW then SB lane 0).

    // Backpressure: response held, no second accept while busy.
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b0;
    addr      = 32'h10;
    funct3    = 3'b010;
    @(posedge clk);
    #1;
    req_we = 1'b1;
    wdata  = 32'h0;
    n = 0;
    while (!resp_valid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("bp_latency", n, LAT);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_resp_valid", {31'd0, resp_valid}, 32'd1);
      chk("bp_read_data",  read_data,           32'h11223355);
      chk("bp_req_ready",  {31'd0, req_ready},  32'd0);
    end
    @(negedge clk);
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    req_valid  = 1'b0;
    chk("bp_release_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("bp_release_req_ready",  {31'd0, req_ready},  32'd1);
    xact(1'b0, 32'h10, 3'b010, 32'h0, rd, mis, lat);
    chk("bp_no_second_store", rd, 32'h11223355);

    // Reset before the commit edge drops the store.
    xact(1'b1, 32'h20, 3'b010, 32'h01020304, rd, mis, lat);
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b1;
    addr      = 32'h20;
    funct3    = 3'b010;
    wdata     = 32'hFFFFFFFF;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("midrst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("midrst_req_ready",  {31'd0, req_ready},  32'd0);
    chk("midrst_read_data",  read_data,           32'h0);
    chk("midrst_misaligned", {31'd0, misaligned}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    xact(1'b0, 32'h20, 3'b010, 32'h0, rd, mis, lat);
    chk("midrst_store_dropped", rd, 32'h01020304);

    // Reset after the commit edge keeps the store.
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b1;
    addr      = 32'h24;
    funct3    = 3'b010;
    wdata     = 32'hCAFEF00D;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    n = 0;
    while (!resp_valid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("late_rst_latency", n, LAT);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    xact(1'b0, 32'h24, 3'b010, 32'h0, rd, mis, lat);
    chk("late_rst_store_kept", rd, 32'hCAFEF00D);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
